cap_clear_regs_seq: RTL and testbench

// Sequencer for CHERI ClearRegs-style bulk clears, upstream of the integer regfile.

---
 rtl/cap_clear_regs_seq.sv | 90 +++++++++
 tb/tb_cap_clear_regs_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cap_clear_regs_seq.sv
// cap_clear_regs_seq: issues a 32-bit register clear mask to the regfile as quarter beats.
// CAP_CLEAR_SKIP_EMPTY_EN: when defined, quarters with an empty mask byte are skipped.
module cap_clear_regs_seq #(
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [31:0]           req_mask_i,
    input  logic [ID_WIDTH-1:0]   req_id_i,
    input  logic                  port_busy_i,
    output logic                  we_o,
    output logic                  clr_o,
    output logic [4:0]            waddr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [7:0]            mask_o,
    output logic [1:0]            quarter_o,
    output logic                  done_o,
    output logic [ID_WIDTH-1:0]   done_id_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t              state;
    logic [31:0]         pend;
    logic [31:0]         pend_nxt;
    logic [31:0]         acc_mask;
    logic [1:0]          q;
    logic [ID_WIDTH-1:0] id;
`ifdef CAP_CLEAR_SKIP_EMPTY_EN
    function automatic logic [1:0] first_q(input logic [31:0] m);
        return (m[7:0] != 8'h00) ? 2'd0 : (m[15:8] != 8'h00) ? 2'd1 :
               (m[23:16] != 8'h00) ? 2'd2 : 2'd3;
    endfunction
`endif
    // x0 is hardwired zero, so it never takes part in a clear
    assign acc_mask    = req_mask_i & ~32'h1;
    assign pend_nxt    = pend & ~(32'hFF << {q, 3'b000});
    assign req_ready_o = (state == IDLE) && !flush_i;
    assign we_o        = (state == RUN) && !port_busy_i && !flush_i;
    assign clr_o       = we_o;
    assign mask_o      = we_o ? pend[{q, 3'b000} +: 8] : 8'h00;
    assign quarter_o   = we_o ? q : 2'd0;
    assign done_o      = (state == DONE) && !flush_i;
    assign done_id_o   = id;
    assign waddr_o     = 5'd0;
    assign wdata_o     = '0;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            pend  <= '0;
            q     <= '0;
            id    <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid_i && req_ready_o) begin
                    pend <= acc_mask;
                    id   <= req_id_i;
`ifdef CAP_CLEAR_SKIP_EMPTY_EN
                    q     <= first_q(acc_mask);
                    state <= (acc_mask == 32'h0) ? DONE : RUN;
`else
                    q     <= 2'd0;
                    state <= RUN;
`endif
                end
                RUN: if (flush_i) begin
                    state <= IDLE;
                    pend  <= '0;
                    q     <= '0;
                end else if (!port_busy_i) begin
                    pend <= pend_nxt;
`ifdef CAP_CLEAR_SKIP_EMPTY_EN
                    q <= first_q(pend_nxt);
                    if (pend_nxt == 32'h0) state <= DONE;
`else
                    q <= q + 2'd1;
                    if (q == 2'd3) state <= DONE;
`endif
                end
                default: begin
                    state <= IDLE;
                    pend  <= '0;
                    q     <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cap_clear_regs_seq.sv
// tb_cap_clear_regs_seq: directed stimulus, checked against a beat-queue model every cycle.
module tb_cap_clear_regs_seq;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_mask_i = '0;
    logic [3:0]  req_id_i = '0;
    logic        port_busy_i = 1'b0;
    logic        we_o, clr_o, done_o;
    logic [4:0]  waddr_o;
    logic [63:0] wdata_o;
    logic [7:0]  mask_o;
    logic [1:0]  quarter_o;
    logic [3:0]  done_id_o;
    int n_chk = 0;
    int n_fail = 0;
    bit started = 1'b0;

    cap_clear_regs_seq #(.DATA_WIDTH(64), .ID_WIDTH(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o), .req_mask_i(req_mask_i), .req_id_i(req_id_i),
        .port_busy_i(port_busy_i), .we_o(we_o), .clr_o(clr_o), .waddr_o(waddr_o),
        .wdata_o(wdata_o), .mask_o(mask_o), .quarter_o(quarter_o), .done_o(done_o),
        .done_id_o(done_id_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: a request becomes a list of pending beats, then one done pulse.
    typedef struct packed { logic [1:0] q; logic [7:0] m; } beat_t;
    beat_t     beats[$];
    bit        m_active = 1'b0;
    logic [3:0] m_id = '0;

    always @(negedge clk) begin
        bit e_ready, e_we, e_done;
        logic [31:0] mm;
        e_ready = !m_active && !flush_i;
        e_we    = m_active && beats.size() != 0 && !port_busy_i && !flush_i;
        e_done  = m_active && beats.size() == 0 && !flush_i;
        if (started) begin
            chk("m_ready", req_ready_o, e_ready);
            chk("m_we", we_o, e_we);
            chk("m_clr", clr_o, e_we);
            chk("m_quarter", quarter_o, e_we ? beats[0].q : 2'd0);
            chk("m_mask", mask_o, e_we ? beats[0].m : 8'h00);
            chk("m_done", done_o, e_done);
            if (e_done) chk("m_done_id", done_id_o, m_id);
            chk("m_waddr", waddr_o, 0);
            chk("m_wdata", wdata_o, 0);
        end
        if (rst_i || (m_active && flush_i)) begin
            m_active = 1'b0;
            beats.delete();
        end else if (e_done) begin
            m_active = 1'b0;
        end else if (e_we) begin
            void'(beats.pop_front());
        end else if (e_ready && req_valid_i) begin
            mm = req_mask_i & 32'hFFFF_FFFE;
            for (int k = 0; k < 4; k++) begin
`ifdef CAP_CLEAR_SKIP_EMPTY_EN
                if (mm[8*k +: 8] != 8'h00) beats.push_back({k[1:0], mm[8*k +: 8]});
`else
                beats.push_back({k[1:0], mm[8*k +: 8]});
`endif
            end
            m_active = 1'b1;
            m_id = req_id_i;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] m, input logic [3:0] i);
        req_valid_i = 1'b1;
        req_mask_i = m;
        req_id_i = i;
        @(negedge clk);
        chk("send_ready", req_ready_o, 1);
        cyc();
        req_valid_i = 1'b0;
    endtask

    task automatic expect_beat(input logic [1:0] q, input logic [7:0] m);
        @(negedge clk);
        chk("beat_we", we_o, 1);
        chk("beat_quarter", quarter_o, q);
        chk("beat_mask", mask_o, m);
        cyc();
    endtask

    task automatic expect_done(input logic [3:0] i);
        @(negedge clk);
        chk("done", done_o, 1);
        chk("done_id", done_id_o, i);
        chk("done_we", we_o, 0);
        cyc();
    endtask

    task automatic expect_quiet();
        @(negedge clk);
        chk("quiet_we", we_o, 0);
        chk("quiet_done", done_o, 0);
        cyc();
    endtask

    task automatic expect_reset();
        @(negedge clk);
        chk("rst_ready", req_ready_o, 1);
        chk("rst_outs", {we_o, clr_o, done_o, mask_o, quarter_o}, 0);
        cyc();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc();
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        started = 1'b1;
        expect_reset();
        // full mask: x0 dropped from the first quarter
        send(32'hFFFF_FFFF, 4'd3);
        expect_beat(2'd0, 8'hFE);
        expect_beat(2'd1, 8'hFF);
        expect_beat(2'd2, 8'hFF);
        expect_beat(2'd3, 8'hFF);
        expect_done(4'd3);
        expect_quiet();
        idle(2);
        send(32'h0100_0001, 4'd5);
`ifdef CAP_CLEAR_SKIP_EMPTY_EN
        expect_beat(2'd3, 8'h01);
`else
        expect_beat(2'd0, 8'h00);
        expect_beat(2'd1, 8'h00);
        expect_beat(2'd2, 8'h00);
        expect_beat(2'd3, 8'h01);
`endif
        expect_done(4'd5);
        idle(2);
        // write port held by commit for three cycles
        send(32'h0000_0F00, 4'd6);
        port_busy_i = 1'b1;
        expect_quiet();
        expect_quiet();
        expect_quiet();
        port_busy_i = 1'b0;
`ifdef CAP_CLEAR_SKIP_EMPTY_EN
        expect_beat(2'd1, 8'h0F);
`else
        expect_beat(2'd0, 8'h00);
        expect_beat(2'd1, 8'h0F);
        expect_beat(2'd2, 8'h00);
        expect_beat(2'd3, 8'h00);
`endif
        expect_done(4'd6);
        idle(2);
        // flush mid-sequence, then a fresh request right away
        send(32'hFFFF_FFFF, 4'd7);
        expect_beat(2'd0, 8'hFE);
        flush_i = 1'b1;
        expect_quiet();
        flush_i = 1'b0;
        send(32'h0000_00F0, 4'd9);
`ifdef CAP_CLEAR_SKIP_EMPTY_EN
        expect_beat(2'd0, 8'hF0);
`else
        expect_beat(2'd0, 8'hF0);
        expect_beat(2'd1, 8'h00);
        expect_beat(2'd2, 8'h00);
        expect_beat(2'd3, 8'h00);
`endif
        expect_done(4'd9);
        idle(2);
        send(32'h0000_0001, 4'd2);
`ifndef CAP_CLEAR_SKIP_EMPTY_EN
        expect_beat(2'd0, 8'h00);
        expect_beat(2'd1, 8'h00);
        expect_beat(2'd2, 8'h00);
        expect_beat(2'd3, 8'h00);
`endif
        expect_done(4'd2);
        idle(2);
        // flush while idle blocks the request entirely
        req_valid_i = 1'b1;
        req_mask_i = 32'h0000_FF00;
        req_id_i = 4'd1;
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush_idle_ready", req_ready_o, 0);
        cyc();
        req_valid_i = 1'b0;
        flush_i = 1'b0;
        expect_quiet();
        expect_quiet();
        // reset during a beat
        send(32'hFFFF_FFFF, 4'd4);
        expect_beat(2'd0, 8'hFE);
        rst_i = 1'b1;
        expect_beat(2'd1, 8'hFF);
        rst_i = 1'b0;
        expect_reset();
        expect_quiet();
        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
